ps2_key_tx: RTL

Synthesizable PS/2 device-side (keyboard) transmitter. It drives the ps2_clk/ps2_data pair that the Minesweeper design's PS/2 receiver consumes, and replaces a behavioural keyboard model in the bench. It accepts one key event per handshake (scan code plus extended/release flags), expands it into a 1–3 byte scan-code sequence and serializes each byte as a standard 11-bit PS/2 frame with an inter-byte gap.

---
 rtl/ps2_pkg.sv | 22 ++
 rtl/ps2_half_tick.sv | 36 +++
 rtl/ps2_key_tx.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: transmitter state encoding, scan-code prefixes
// and the 11-bit frame builder (also used by the receiver side).
package ps2_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        HI,
        LO,
        GAP
    } ps2_tx_state_t;

    localparam logic [7:0] PS2_EXT_PREFIX   = 8'hE0;
    localparam logic [7:0] PS2_BREAK_PREFIX = 8'hF0;
    localparam int         PS2_FRAME_BITS   = 11;

    // Frame bit 0 goes on the wire first: start 0, d0..d7, odd parity, stop 1.
    function automatic logic [PS2_FRAME_BITS-1:0] ps2_frame(input logic [7:0] data);
        return {1'b1, ~^data, data, 1'b0};
    endfunction

endpackage

// File: rtl/ps2_half_tick.sv
// PS/2 half-period divider: counts 0..CLK_DIV-1 while enabled and flags the
// last count as a tick. Clear forces the count back to zero.
module ps2_half_tick #(
    parameter int CLK_DIV = 2000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int             CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]  LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = en && (cnt_q == LAST);

    // Next count: clear wins, otherwise wrap on tick.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + CW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/ps2_key_tx.sv
// PS/2 device-side transmitter: expands one key event into 1-3 scan-code
// bytes and shifts each out as an 11-bit frame followed by an idle gap.
//
// state | meaning
// IDLE  | lines high, ready for an event, divider held at 0
// LOAD  | zero-cycle step: pick next byte, build its frame, go to HI
// HI    | ps2_clk high, current bit presented on ps2_data
// LO    | ps2_clk low, data held for the host to sample
// GAP   | both lines high for GAP_HALF half-periods after each byte
module ps2_key_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV  = 2000,
    parameter int GAP_HALF = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] tx_code,
    input  logic       tx_ext,
    input  logic       tx_release,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       ps2_clk,
    output logic       ps2_data,
    output logic       tx_done
);

    localparam int                GW       = (GAP_HALF > 1) ? $clog2(GAP_HALF) : 1;
    localparam logic [GW-1:0]     GAP_LAST = GW'(GAP_HALF - 1);
    localparam logic [3:0]        LAST_BIT = 4'(PS2_FRAME_BITS - 1);

    ps2_tx_state_t             state_q, state_d;
    logic [3:0]                bit_idx_q, bit_idx_d;
    logic [1:0]                byte_idx_q, byte_idx_d;
    logic [1:0]                last_idx_q, last_idx_d;
    logic [GW-1:0]             gap_cnt_q, gap_cnt_d;
    logic [2:0][7:0]           bytes_q, bytes_d;
    logic [PS2_FRAME_BITS-1:0] frame_q, frame_d;
    logic                      ps2_clk_q, ps2_clk_d;
    logic                      ps2_data_q, ps2_data_d;
    logic                      tx_done_q, tx_done_d;
    logic [7:0]                sel_byte;
    logic                      tick;

    ps2_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
        .clk   (clk),
        .reset (reset),
        .en    (state_q != IDLE),
        .clr   (state_q == IDLE),
        .tick  (tick)
    );

    assign tx_ready = (state_q == IDLE);
    assign ps2_clk  = ps2_clk_q;
    assign ps2_data = ps2_data_q;
    assign tx_done  = tx_done_q;

    // Next state, byte queue build, frame load and registered line values.
    always_comb begin
        state_d    = state_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        last_idx_d = last_idx_q;
        gap_cnt_d  = gap_cnt_q;
        bytes_d    = bytes_q;
        frame_d    = frame_q;
        tx_done_d  = 1'b0;
        sel_byte   = 8'h00;

        case (state_q)
            IDLE: begin
                if (tx_valid) begin
                    byte_idx_d = 2'd0;
                    if (tx_ext) begin
                        bytes_d[0] = PS2_EXT_PREFIX;
                        if (tx_release) begin
                            bytes_d[1] = PS2_BREAK_PREFIX;
                            bytes_d[2] = tx_code;
                            last_idx_d = 2'd2;
                        end else begin
                            bytes_d[1] = tx_code;
                            last_idx_d = 2'd1;
                        end
                    end else if (tx_release) begin
                        bytes_d[0] = PS2_BREAK_PREFIX;
                        bytes_d[1] = tx_code;
                        last_idx_d = 2'd1;
                    end else begin
                        bytes_d[0] = tx_code;
                        last_idx_d = 2'd0;
                    end
                    state_d = LOAD;
                end
            end
            HI: begin
                if (tick) state_d = LO;
            end
            LO: begin
                if (tick) begin
                    if (bit_idx_q < LAST_BIT) begin
                        bit_idx_d = bit_idx_q + 4'd1;
                        state_d   = HI;
                    end else begin
                        gap_cnt_d = '0;
                        state_d   = GAP;
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (gap_cnt_q == GAP_LAST) begin
                        if (byte_idx_q == last_idx_q) begin
                            tx_done_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            byte_idx_d = byte_idx_q + 2'd1;
                            state_d    = LOAD;
                        end
                    end else begin
                        gap_cnt_d = gap_cnt_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // LOAD resolves in the same cycle so the start bit appears right away.
        if (state_d == LOAD) begin
            case (byte_idx_d)
                2'd0:    sel_byte = bytes_d[0];
                2'd1:    sel_byte = bytes_d[1];
                default: sel_byte = bytes_d[2];
            endcase
            frame_d   = ps2_frame(sel_byte);
            bit_idx_d = 4'd0;
            state_d   = HI;
        end

        ps2_clk_d  = (state_d != LO);
        ps2_data_d = ((state_d == HI) || (state_d == LO)) ? frame_d[bit_idx_d] : 1'b1;
    end

    // State and output registers; reset drops any event in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_idx_q  <= 4'd0;
            byte_idx_q <= 2'd0;
            last_idx_q <= 2'd0;
            gap_cnt_q  <= '0;
            bytes_q    <= '0;
            frame_q    <= '1;
            ps2_clk_q  <= 1'b1;
            ps2_data_q <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            last_idx_q <= last_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            bytes_q    <= bytes_d;
            frame_q    <= frame_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_data_q <= ps2_data_d;
            tx_done_q  <= tx_done_d;
        end
    end

endmodule
